// File: rtl/cpu_handshake_sender.sv
// Initiator end of a 4-phase SEND/ACK link: latches a word on request, walks
// SEND through raise / wait-ACK-high / drop / wait-ACK-low, with a per-phase
// timeout, a sticky error flag and a completed-transfer counter.
module cpu_handshake_sender #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_cpu,
    input  logic             rst_cpu,
    input  logic             start_cpu,
    input  logic [31:0]      inputData_cpu,
    input  logic             ACK_cpu,
    output logic             SEND_cpu,
    output logic [31:0]      outData_cpu,
    output logic             busy_cpu,
    output logic             done_cpu,
    output logic             timeout_cpu,
    output logic [CNT_W-1:0] xferCount_cpu
);

    localparam int unsigned DATA_W   = 32;
    // Fewer than two synchronizer flops is never safe; clamp silently.
    localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    // Timer only needs to reach TIMEOUT_CYCLES-1 before the phase is abandoned.
    localparam int unsigned TMR_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TMR_LAST = TMO_EN ? (TIMEOUT_CYCLES - 1) : 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_REL  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_n;
    logic [SYNC_N-1:0]   ack_sync_q;
    logic                ack_s;
    logic [TMR_W-1:0]    timer_q, timer_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic                tmo_q, tmo_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                send_q;
    logic                busy_q;
    logic                done_q;
    logic                tmr_hit_c;

    // ACK crosses from the peripheral clock domain through a plain flop chain.
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_N-2:0], ACK_cpu};
        end
    end

    assign ack_s = ack_sync_q[SYNC_N-1];

    // Phase budget exhausted when the timer sits on its last allowed value.
    assign tmr_hit_c = TMO_EN && (timer_q == TMR_W'(TMR_LAST));

    // FSM state, timer, latched data, error flag and counter registers.
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            data_q  <= data_n;
            tmo_q   <= tmo_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next-state logic; only the synchronized ACK steers the phases.
    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        data_n  = data_q;
        tmo_n   = tmo_q;
        cnt_n   = cnt_q;

        case (state_q)
            S_IDLE: begin
                // A still-high ACK from a previous cycle blocks acceptance.
                if (start_cpu && !ack_s) begin
                    state_n = S_REQ;
                    data_n  = inputData_cpu;
                    tmo_n   = 1'b0;
                    timer_n = '0;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    state_n = S_REL;
                    timer_n = '0;
                end else if (tmr_hit_c) begin
                    state_n = S_ERR;
                end else if (TMO_EN) begin
                    timer_n = timer_q + TMR_W'(1);
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    state_n = S_DONE;
                end else if (tmr_hit_c) begin
                    state_n = S_ERR;
                end else if (TMO_EN) begin
                    timer_n = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = cnt_q + CNT_W'(1);
            end
            S_ERR: begin
                tmo_n = 1'b1;
                // Wait for the peripheral to release ACK before re-arming.
                if (!ack_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs follow the state one edge later.
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            send_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            send_q <= (state_q == S_REQ);
            busy_q <= (state_q != S_IDLE);
            done_q <= (state_q == S_DONE);
        end
    end

    assign SEND_cpu      = send_q;
    assign outData_cpu   = data_q;
    assign busy_cpu      = busy_q;
    assign done_cpu      = done_q;
    assign timeout_cpu   = tmo_q;
    assign xferCount_cpu = cnt_q;

endmodule

// File: tb/tb_cpu_handshake_sender.sv
// Directed bench for cpu_handshake_sender: stimulus queues expected
// completions, a negedge monitor pops and compares them as they appear.
module tb_cpu_handshake_sender;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CW   = 2;

    logic          clk_cpu       = 1'b0;
    logic          rst_cpu       = 1'b1;
    logic          start_cpu     = 1'b0;
    logic [31:0]   inputData_cpu = 32'h0;
    logic          ACK_cpu;
    logic          SEND_cpu;
    logic [31:0]   outData_cpu;
    logic          busy_cpu;
    logic          done_cpu;
    logic          timeout_cpu;
    logic [CW-1:0] xferCount_cpu;

    cpu_handshake_sender #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .clk_cpu      (clk_cpu),
        .rst_cpu      (rst_cpu),
        .start_cpu    (start_cpu),
        .inputData_cpu(inputData_cpu),
        .ACK_cpu      (ACK_cpu),
        .SEND_cpu     (SEND_cpu),
        .outData_cpu  (outData_cpu),
        .busy_cpu     (busy_cpu),
        .done_cpu     (done_cpu),
        .timeout_cpu  (timeout_cpu),
        .xferCount_cpu(xferCount_cpu)
    );

    always #5 clk_cpu = ~clk_cpu;

    // ACK source: either a forced level or the responding peripheral model.
    logic force_en  = 1'b0;
    logic force_val = 1'b0;
    logic ack_model = 1'b0;
    assign ACK_cpu = force_en ? force_val : ack_model;

    typedef struct {
        bit          is_tmo;
        logic [31:0] data;
        logic [CW-1:0] cnt;
        int          width;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic push(input bit is_tmo, input logic [31:0] data, input logic [CW-1:0] cnt,
                        input int width);
        exp_t e;
        e.is_tmo = is_tmo;
        e.data   = data;
        e.cnt    = cnt;
        e.width  = width;
        exp_q.push_back(e);
    endtask

    // Peripheral: raise ACK 3 cycles after SEND rises, drop it 3 after SEND falls.
    bit periph_en = 1'b1;
    int pcnt      = 0;
    always @(negedge clk_cpu) begin
        if (!periph_en) begin
            ack_model = 1'b0;
            pcnt      = 0;
        end else if (SEND_cpu != ack_model) begin
            pcnt++;
            if (pcnt >= 3) begin
                ack_model = SEND_cpu;
                pcnt      = 0;
            end
        end else begin
            pcnt = 0;
        end
    end

    // Monitor: pops an expectation on each done pulse or timeout rising edge.
    bit send_prev = 1'b0;
    bit done_prev = 1'b0;
    bit tmo_prev  = 1'b0;
    int send_width = 0;
    int rises      = 0;
    always @(negedge clk_cpu) begin : mon
        exp_t e;
        if (rst_cpu) begin
            send_prev  = 1'b0;
            done_prev  = 1'b0;
            tmo_prev   = 1'b0;
            send_width = 0;
            rises      = 0;
        end else begin
            if (SEND_cpu) begin
                if (!send_prev) begin
                    rises++;
                    send_width = 0;
                end
                send_width++;
            end
            if (done_cpu) begin
                chk("done_single_cycle", 32'(done_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 32'd0, 32'(e.is_tmo));
                    chk("done_data", outData_cpu, e.data);
                    chk("done_count", 32'(xferCount_cpu), 32'(e.cnt));
                    chk("done_send_rises", rises, 1);
                end
                rises = 0;
            end
            if (timeout_cpu && !tmo_prev) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_timeout");
                end else begin
                    e = exp_q.pop_front();
                    chk("tmo_kind", 32'd1, 32'(e.is_tmo));
                    chk("tmo_count", 32'(xferCount_cpu), 32'(e.cnt));
                    chk("tmo_send_width", send_width, e.width);
                    chk("tmo_no_done", 32'(done_cpu), 32'd0);
                end
                rises = 0;
            end
            send_prev = SEND_cpu;
            done_prev = done_cpu;
            tmo_prev  = timeout_cpu;
        end
    end

    function automatic logic get_sig(input int which);
        return (which == 0) ? busy_cpu : SEND_cpu;
    endfunction

    // Bounded wait for busy (0) or SEND (1) to reach a level.
    task automatic wait_sig(input string name, input int which, input logic lvl, input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge clk_cpu);
            if (get_sig(which) == lvl) return;
        end
        fail_now(name);
    endtask

    task automatic do_reset();
        start_cpu = 1'b0;
        rst_cpu   = 1'b1;
        repeat (2) @(negedge clk_cpu);
        rst_cpu = 1'b0;
        @(negedge clk_cpu);
    endtask

    // One request; data is scrambled while busy to prove it is not re-sampled.
    task automatic send_word(input logic [31:0] data, input logic [CW-1:0] cnt);
        push(1'b0, data, cnt, 0);
        @(negedge clk_cpu);
        start_cpu     = 1'b1;
        inputData_cpu = data;
        wait_sig("send_busy_rise", 0, 1'b1, 20);
        start_cpu     = 1'b0;
        inputData_cpu = ~data;
        wait_sig("send_busy_fall", 0, 1'b0, 60);
    endtask

    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset state.
        repeat (2) @(negedge clk_cpu);
        chk("rst_send", 32'(SEND_cpu), 32'd0);
        chk("rst_data", outData_cpu, 32'd0);
        chk("rst_busy", 32'(busy_cpu), 32'd0);
        chk("rst_done", 32'(done_cpu), 32'd0);
        chk("rst_tmo", 32'(timeout_cpu), 32'd0);
        chk("rst_count", 32'(xferCount_cpu), 32'd0);
        rst_cpu = 1'b0;
        @(negedge clk_cpu);

        // Basic transfer.
        send_word(32'hDEADBEEF, 2'd1);
        repeat (3) @(negedge clk_cpu);

        // Back-to-back with start held high across three words.
        do_reset();
        push(1'b0, 32'h1, 2'd1, 0);
        push(1'b0, 32'h2, 2'd2, 0);
        push(1'b0, 32'h3, 2'd3, 0);
        start_cpu     = 1'b1;
        inputData_cpu = 32'h1;
        wait_sig("b2b_busy1", 0, 1'b1, 20);
        inputData_cpu = 32'h2;
        wait_sig("b2b_gap1", 0, 1'b0, 60);
        wait_sig("b2b_busy2", 0, 1'b1, 20);
        inputData_cpu = 32'h3;
        wait_sig("b2b_gap2", 0, 1'b0, 60);
        wait_sig("b2b_busy3", 0, 1'b1, 20);
        start_cpu     = 1'b0;
        inputData_cpu = 32'h0;
        wait_sig("b2b_end", 0, 1'b0, 60);
        repeat (3) @(negedge clk_cpu);
        chk("b2b_count", 32'(xferCount_cpu), 32'd3);

        // Stale ACK held through reset release blocks the request.
        force_val = 1'b1;
        force_en  = 1'b1;
        do_reset();
        repeat (4) @(negedge clk_cpu);
        start_cpu     = 1'b1;
        inputData_cpu = 32'hA5A50F0F;
        repeat (10) @(negedge clk_cpu);
        chk("stale_send_low", 32'(SEND_cpu), 32'd0);
        chk("stale_busy_low", 32'(busy_cpu), 32'd0);
        push(1'b0, 32'hA5A50F0F, 2'd1, 0);
        force_en = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk_cpu);
                n++;
            end while (!SEND_cpu && n < 20);
            chk("stale_send_latency", n, SYNC + 2);
        end
        start_cpu = 1'b0;
        wait_sig("stale_end", 0, 1'b0, 60);
        repeat (3) @(negedge clk_cpu);

        // Timeout: peripheral silent, SEND high for exactly TMO cycles.
        do_reset();
        periph_en = 1'b0;
        push(1'b1, 32'h12345678, 2'd0, TMO);
        start_cpu     = 1'b1;
        inputData_cpu = 32'h12345678;
        wait_sig("tmo_busy_rise", 0, 1'b1, 20);
        start_cpu = 1'b0;
        wait_sig("tmo_busy_fall", 0, 1'b0, 40);
        chk("tmo_flag_sticky", 32'(timeout_cpu), 32'd1);
        chk("tmo_count_kept", 32'(xferCount_cpu), 32'd0);
        periph_en = 1'b1;
        push(1'b0, 32'h0BADF00D, 2'd1, 0);
        @(negedge clk_cpu);
        start_cpu     = 1'b1;
        inputData_cpu = 32'h0BADF00D;
        wait_sig("tmo_clear_busy", 0, 1'b1, 20);
        chk("tmo_cleared_on_start", 32'(timeout_cpu), 32'd0);
        start_cpu = 1'b0;
        wait_sig("tmo_clear_end", 0, 1'b0, 60);
        repeat (3) @(negedge clk_cpu);

        // Reset asserted while waiting for ACK to drop.
        do_reset();
        start_cpu     = 1'b1;
        inputData_cpu = 32'hCAFEF00D;
        wait_sig("rel_send_rise", 1, 1'b1, 20);
        start_cpu = 1'b0;
        wait_sig("rel_send_fall", 1, 1'b0, 30);
        rst_cpu = 1'b1;
        #1;
        chk("relrst_send", 32'(SEND_cpu), 32'd0);
        chk("relrst_data", outData_cpu, 32'd0);
        chk("relrst_busy", 32'(busy_cpu), 32'd0);
        chk("relrst_done", 32'(done_cpu), 32'd0);
        chk("relrst_tmo", 32'(timeout_cpu), 32'd0);
        chk("relrst_count", 32'(xferCount_cpu), 32'd0);
        repeat (2) @(negedge clk_cpu);
        rst_cpu = 1'b0;
        repeat (12) @(negedge clk_cpu);
        chk("relrst_idle_busy", 32'(busy_cpu), 32'd0);

        // Counter wrap with a 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_word(32'h100 + 32'(i), CW'(wrap_exp[i]));
        end
        repeat (5) @(negedge clk_cpu);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
